// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes rx_in, samples each bit at its centre and
// presents completed bytes on a valid/ready handshake with error pulses.
module uart_receiver #(
  parameter int unsigned CLK_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W    = $clog2(CLK_PER_BIT);
  localparam int unsigned HALF_BIT = CLK_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic             r_rxs1;
  logic             r_rxs2;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_done;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic [2:0] w_state_nxt;
  logic       w_cnt_run;
  logic       w_cnt_last;
  logic       w_bit_en;
  logic       w_done;
  logic       w_ferr;

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

  // Two-flop synchronizer; everything downstream uses r_rxs2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxs1 <= 1'b1;
      r_rxs2 <= 1'b1;
    end else begin
      r_rxs1 <= rx_in;
      r_rxs2 <= r_rxs1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_cnt_last = (r_state == START) ? (r_cnt == HALF_LAST) : (r_cnt == BIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_run   = 1'b0;
    w_bit_en    = 1'b0;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rxs2) w_state_nxt = START;
      end
      START: begin
        w_cnt_run = 1'b1;
        if (w_cnt_last) w_state_nxt = r_rxs2 ? IDLE : DATA;
      end
      DATA: begin
        w_cnt_run = 1'b1;
        if (w_cnt_last) begin
          w_bit_en = 1'b1;
          if (r_idx == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        w_cnt_run = 1'b1;
        if (w_cnt_last) begin
          if (r_rxs2) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (r_rxs2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit timer restarts at each sample point and whenever the FSM is not timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      if (w_cnt_run && !w_cnt_last) r_cnt <= r_cnt + CNT_W'(1);
      else                          r_cnt <= '0;
      if (r_state != DATA) r_idx <= 3'd0;
      else if (w_bit_en)   r_idx <= r_idx + 3'd1;
      if (w_bit_en) r_shift[r_idx] <= r_rxs2;
    end
  end

  // Output stage: load one edge after the stop sample; a held byte blocks new ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done      <= 1'b0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done      <= w_done;
      r_frame_err <= w_ferr;
      r_overrun   <= 1'b0;
      if (r_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
